// File: rtl/allophone_feeder.sv
// allophone_feeder: buffers 6-bit allophone codes from a host and hands them
// one at a time to a speech core using its ldq/data_stb load handshake.
//
// Ports:
//   clk, rst_an           clock (rising edge) and asynchronous active-low reset
//   host_data, host_wr    host code and write strobe (one code per high cycle)
//   fifo_full, overflow   FIFO at capacity / sticky "a host write was dropped"
//   level                 current FIFO occupancy (0..DEPTH)
//   ldq                   speech core load request (high = ready for a code)
//   data_in, data_stb     code to the speech core and its one-cycle qualifier
//   busy                  handshake in progress or codes still queued
//
// Optional feature: define ALLOPHONE_FEEDER_AUTOPAUSE_EN to make the feeder
// append a PA4 pause (code 6'h03) once the queue runs dry after speech.

// Generic synchronous FIFO, registered count, head visible combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: a push while full is refused even if a pop happens that cycle.
module allophone_fifo #(
  parameter int DW = 6,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_an,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign pop_dat = mem[rd_ptr];

  // Fullness is judged on the current count only, so a simultaneous pop never
  // makes room for a write in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap at DEPTH on their own.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// Host-to-speech-core allophone feeder: FIFO plus a three-state load handshake.
// Latency: data_stb one cycle after ldq is seen high in IDLE with a code queued.
// Backpressure: host writes are dropped (overflow set) when the FIFO is full.
module allophone_feeder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_an,
  input  logic [5:0]          host_data,
  input  logic                host_wr,
  output logic                fifo_full,
  output logic                overflow,
  output logic [DEPTH_LOG2:0] level,
  input  logic                ldq,
  output logic [5:0]          data_in,
  output logic                data_stb,
  output logic                busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_STB      = 2'd1;
  localparam logic [1:0] S_WAIT_LOW = 2'd2;

`ifdef ALLOPHONE_FEEDER_AUTOPAUSE_EN
  localparam logic [5:0] PAUSE_CODE = 6'h03;  // PA4 pause allophone
`endif

  logic [1:0]          state;
  logic [5:0]          head_dat;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [DEPTH_LOG2:0] fifo_level;

  // A queued code is only taken when the core asks for one while idle.
  assign fifo_pop = (state == S_IDLE) && ldq && !fifo_empty;

  allophone_fifo #(
    .DW (6),
    .AW (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst_an   (rst_an),
    .push     (host_wr),
    .push_dat (host_data),
    .pop      (fifo_pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign level = fifo_level;
  assign busy  = (state != S_IDLE) || !fifo_empty;

  // Sticky until reset; a write refused by a full FIFO is lost for good.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      overflow <= 1'b0;
    end else if (host_wr && fifo_full) begin
      overflow <= 1'b1;
    end
  end

`ifdef ALLOPHONE_FEEDER_AUTOPAUSE_EN
  // Remembers that speech was sent since the last pause, so a single pause
  // is appended once the queue runs dry and the core asks again.
  logic pause_pend;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      pause_pend <= 1'b0;
    end else if (fifo_pop) begin
      pause_pend <= 1'b1;
    end else if ((state == S_IDLE) && ldq && pause_pend) begin
      pause_pend <= 1'b0;
    end
  end
`endif

  // Handshake FSM. data_stb defaults low every cycle, so it can only ever be
  // a single-cycle pulse leaving IDLE; data_in holds until the next strobe.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state    <= S_IDLE;
      data_in  <= 6'h00;
      data_stb <= 1'b0;
    end else begin
      data_stb <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            data_in  <= head_dat;
            data_stb <= 1'b1;
            state    <= S_STB;
          end
`ifdef ALLOPHONE_FEEDER_AUTOPAUSE_EN
          else if (ldq && pause_pend) begin
            data_in  <= PAUSE_CODE;
            data_stb <= 1'b1;
            state    <= S_STB;
          end
`endif
        end
        S_STB: begin
          state <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          // The core must drop ldq before another code is offered.
          if (!ldq) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_allophone_feeder.sv
module tb_allophone_feeder;

  logic       clk;
  logic       rst_an;
  logic [5:0] host_data;
  logic       host_wr;
  logic       fifo_full;
  logic       overflow;
  logic [4:0] level;
  logic       ldq;
  logic [5:0] data_in;
  logic       data_stb;
  logic       busy;

  int checks;
  int failures;

  allophone_feeder #(.DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .rst_an    (rst_an),
    .host_data (host_data),
    .host_wr   (host_wr),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .level     (level),
    .ldq       (ldq),
    .data_in   (data_in),
    .data_stb  (data_stb),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] d);
    host_data = d;
    host_wr   = 1'b1;
    tick();
    host_wr   = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_an    = 1'b0;
    host_data = 6'h00;
    host_wr   = 1'b0;
    ldq       = 1'b0;

    // Reset state
    #1;
    chk("rst_stb", 32'(data_stb), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_full", 32'(fifo_full), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_data", 32'(data_in), 32'h0);
    tick();
    tick();
    rst_an = 1'b1;
    tick();

    // Three codes, in-order delivery through the handshake
    wr(6'h1B);
    wr(6'h07);
    wr(6'h2D);
    chk("q3_level", 32'(level), 32'd3);
    chk("q3_busy", 32'(busy), 32'h1);
    chk("q3_stb", 32'(data_stb), 32'h0);
    ldq = 1'b1;
    tick();
    chk("s1_stb", 32'(data_stb), 32'h1);
    chk("s1_data", 32'(data_in), 32'h1B);
    chk("s1_level", 32'(level), 32'd2);
    tick();
    chk("s1_stb_low", 32'(data_stb), 32'h0);
    chk("s1_data_hold", 32'(data_in), 32'h1B);
    tick();
    chk("s1_wait_stb", 32'(data_stb), 32'h0);
    ldq = 1'b0;
    tick();
    ldq = 1'b1;
    tick();
    chk("s2_stb", 32'(data_stb), 32'h1);
    chk("s2_data", 32'(data_in), 32'h07);
    chk("s2_level", 32'(level), 32'd1);
    tick();
    ldq = 1'b0;
    tick();
    ldq = 1'b1;
    tick();
    chk("s3_stb", 32'(data_stb), 32'h1);
    chk("s3_data", 32'(data_in), 32'h2D);
    chk("s3_level", 32'(level), 32'd0);
    tick();
    chk("s3_busy_wait", 32'(busy), 32'h1);

    // ldq held high: a newly queued code must wait for ldq to cycle
    wr(6'h11);
    chk("hold_level", 32'(level), 32'd1);
    chk("hold_stb0", 32'(data_stb), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_stb", 32'(data_stb), 32'h0);
    end
    ldq = 1'b0;
    tick();
    ldq = 1'b1;
    tick();
    chk("s4_stb", 32'(data_stb), 32'h1);
    chk("s4_data", 32'(data_in), 32'h11);
    tick();
    ldq = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // Empty FIFO with ldq high: nothing, or one auto-pause when enabled
    ldq = 1'b1;
    tick();
`ifdef ALLOPHONE_FEEDER_AUTOPAUSE_EN
    chk("pause_stb", 32'(data_stb), 32'h1);
    chk("pause_data", 32'(data_in), 32'h03);
    tick();
    chk("pause_stb_low", 32'(data_stb), 32'h0);
    ldq = 1'b0;
    tick();
    ldq = 1'b1;
    tick();
    chk("pause_once", 32'(data_stb), 32'h0);
    tick();
    chk("pause_once2", 32'(data_stb), 32'h0);
`else
    chk("empty_stb", 32'(data_stb), 32'h0);
    chk("empty_data", 32'(data_in), 32'h11);
    tick();
    chk("empty_stb2", 32'(data_stb), 32'h0);
    tick();
    chk("empty_stb3", 32'(data_stb), 32'h0);
`endif
    ldq = 1'b0;
    tick();

    // Write into empty FIFO while ldq high in IDLE: strobe two cycles later
    ldq = 1'b1;
    wr(6'h2A);
    chk("lat_stb_early", 32'(data_stb), 32'h0);
    chk("lat_level", 32'(level), 32'd1);
    tick();
    chk("lat_stb", 32'(data_stb), 32'h1);
    chk("lat_data", 32'(data_in), 32'h2A);
    tick();
    ldq = 1'b0;
    tick();

    // Fill to capacity, then one more write overflows
    for (int i = 0; i < 16; i++) begin
      wr(6'(32 + i));
    end
    chk("fill_full", 32'(fifo_full), 32'h1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_ovf0", 32'(overflow), 32'h0);
    wr(6'h30);
    chk("ovf_full", 32'(fifo_full), 32'h1);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'h1);

    // Full FIFO: write in the same cycle as a pop is still dropped
    host_data = 6'h3F;
    host_wr   = 1'b1;
    ldq       = 1'b1;
    tick();
    host_wr   = 1'b0;
    chk("popwr_stb", 32'(data_stb), 32'h1);
    chk("popwr_data", 32'(data_in), 32'h20);
    chk("popwr_level", 32'(level), 32'd15);
    chk("popwr_full", 32'(fifo_full), 32'h0);
    chk("popwr_ovf", 32'(overflow), 32'h1);
    tick();
    ldq = 1'b0;
    tick();
    for (int i = 1; i < 16; i++) begin
      ldq = 1'b1;
      tick();
      chk("drain_stb", 32'(data_stb), 32'h1);
      chk("drain_data", 32'(data_in), 32'(32 + i));
      tick();
      ldq = 1'b0;
      tick();
    end
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_ovf", 32'(overflow), 32'h1);

    // Reset during STB with queued codes
    for (int i = 1; i <= 5; i++) begin
      wr(6'(i));
    end
    ldq = 1'b1;
    tick();
    chk("pre_rst_stb", 32'(data_stb), 32'h1);
    chk("pre_rst_level", 32'(level), 32'd4);
    rst_an = 1'b0;
    #1;
    chk("mid_rst_stb", 32'(data_stb), 32'h0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ovf", 32'(overflow), 32'h0);
    chk("mid_rst_data", 32'(data_in), 32'h0);
    tick();
    rst_an = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_stb", 32'(data_stb), 32'h0);
    end
    wr(6'h15);
    chk("post_rst_wr_stb", 32'(data_stb), 32'h0);
    tick();
    chk("post_rst_new_stb", 32'(data_stb), 32'h1);
    chk("post_rst_new_data", 32'(data_in), 32'h15);
    ldq = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
